mux_reg_n_para_1: RTL and testbench
===================================

# mux_reg_n_para_1

Parametrised, registered N-to-1 word multiplexer with a valid/ready handshake and an auto-scan mode. It generalises the fixed 8:1 single-bit selector to WIDTH-bit channels and N inputs. It adds a one-entry output register with backpressure and a scan counter that walks channels 0..N-1 without external select logic. The ULA datapath uses it to feed operand and result words into downstream stages that may stall.

## Interface
- WIDTH, 4, bits per channel word.
- N, 8, number of input channels (2..256).
- SEL_W, 3, select width; must equal ceil(log2(N)).
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- D  input  N*WIDTH  channel words, flat; channel k is D[k*WIDTH +: WIDTH].
- S  input  SEL_W  channel select, used in direct mode.
- MODE  input  1  0 = direct (select from S), 1 = scan (select from internal counter).
- in_valid  input  1  upstream offers the current D/S for capture.
- in_ready  output  1  block can capture this cycle.
- Y  output  WIDTH  registered selected word.
- Y_SEL  output  SEL_W  channel index that produced Y.
- out_valid  output  1  Y/Y_SEL/WRAP/ERR hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- WRAP  output  1  set with the word when the scan counter wrapped (channel N-1 captured in scan mode).
- ERR  output  1  set with the word when the selected index is >= N.

## Operation
- Effective select: sel = S when MODE=0, sel = cnt when MODE=1.
- in_ready = !out_valid || out_ready (combinational; single-entry pipeline, full throughput).
- Capture when in_valid && in_ready:
  - Y <= D[sel] if sel < N, else 0.
  - Y_SEL <= sel.
  - ERR <= (sel >= N).
  - WRAP <= MODE && (cnt == N-1).
  - out_valid <= 1.
- No capture and out_ready=1: out_valid <= 0. Y/Y_SEL/WRAP/ERR hold their last values; they are don't-care while out_valid=0.
- No capture and out_ready=0: all output registers hold.
- Scan counter cnt (SEL_W bits):
  - MODE=0: cnt <= 0 every cycle, so scan always restarts at channel 0.
  - MODE=1 and capture: cnt <= (cnt == N-1) ? 0 : cnt+1.
  - MODE=1 and no capture: cnt holds.
  - In scan mode ERR is never set.
- MODE changes take effect on the same cycle's sel. No flush is done: a word already held in the output register is delivered unchanged.
- rst=1, regardless of other inputs:
  - Next edge: out_valid=0, Y=0, Y_SEL=0, WRAP=0, ERR=0, cnt=0.
  - in_ready reads 1 in the cycle after the edge, once out_valid is 0.
  - A word pending at reset is discarded.

## Timing
- Latency: 1 cycle from capture edge to out_valid=1 with the word.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous capture and drain (out_valid=1, out_ready=1, in_valid=1): the old word is consumed, the new word is loaded on the same edge, and out_valid stays 1.
- Stall: with out_valid=1 and out_ready=0, in_ready=0. D, S and MODE are ignored and cnt does not advance.
- Reset has priority over capture and drain on the same edge.
- Upstream contract: D/S are sampled only on the capture edge and need not be held afterwards.

## Test plan
- Reset then direct mode:
  - N=8, WIDTH=4, D[k]=k+3, MODE=0, out_ready=1, S=0..7 one per cycle with in_valid=1.
  - Required: one cycle later Y = 3..10 (mod 16), Y_SEL = 0..7, out_valid=1 each cycle, ERR=0, WRAP=0.
- Scan wrap:
  - MODE=1, in_valid=1, out_ready=1 for 10 cycles.
  - Required: Y_SEL = 0,1,..,7,0,1; WRAP=1 only with Y_SEL=7; Y=D[Y_SEL].
- Backpressure:
  - Capture channel 2, then hold out_ready=0 for 3 cycles while D and S change.
  - Required: in_ready=0; Y, Y_SEL=2 and out_valid=1 stable. After out_ready=1 the next word is captured, and in scan mode cnt has not advanced during the stall.
- Out-of-range select:
  - N=6 (SEL_W=3), MODE=0, S=7, in_valid=1.
  - Required: Y=0, Y_SEL=7, ERR=1. A following capture with S=5 gives ERR=0 and Y=D[5].
- Mode switch mid-scan:
  - Scan to cnt=4, switch MODE=0 for one capture with S=1, then MODE=1.
  - Required: the words show Y_SEL = ..,3,1,0,1,..; scan restarts at 0.
- Reset mid-operation:
  - out_valid=1, out_ready=0, cnt=5, assert rst for 1 cycle with in_valid=1.
  - Required: the next cycle has out_valid=0, Y=0, WRAP=0, ERR=0, in_ready=1. The first scan capture after reset has Y_SEL=0.

Source files
------------

// File: rtl/mux_reg_n_para_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_reg_n_para_1
//  Description : Parametrised, registered N-to-1 word multiplexer with a
//                valid/ready handshake and an auto-scan mode. A one-entry
//                output register absorbs downstream stalls. A scan counter
//                walks channels 0..N-1 without any external select logic.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      bits per channel word
//    N          number of input channels (2..256)
//    SEL_W      select width, must equal $clog2(N)
//  Ports
//    clk        rising-edge clock, sole clock
//    rst        synchronous active-high reset
//    D          N*WIDTH flat channel words, channel k at D[k*WIDTH +: WIDTH]
//    S          direct-mode channel select
//    MODE       0 = select from S, 1 = select from the internal scan counter
//    in_valid   upstream offers D/S for capture this cycle
//    in_ready   block can capture this cycle
//    Y          registered selected word
//    Y_SEL      channel index that produced Y
//    out_valid  Y/Y_SEL/WRAP/ERR hold a valid word
//    out_ready  downstream accepts the word this cycle
//    WRAP       word was captured from channel N-1 in scan mode
//    ERR        word was captured with a select index >= N
// ============================================================================
module mux_reg_n_para_1 #(
    parameter int WIDTH = 4,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   D,
    input  logic [SEL_W-1:0]     S,
    input  logic                 MODE,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     Y,
    output logic [SEL_W-1:0]     Y_SEL,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 WRAP,
    output logic                 ERR
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N - 1);
    localparam logic [31:0]      c_n       = 32'(N);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SEL_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic [SEL_W-1:0] y_sel_q,     y_sel_d;
    logic             wrap_q,      wrap_d;
    logic             err_q,       err_d;
    logic             out_valid_q, out_valid_d;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [SEL_W-1:0] w_sel;
    logic [WIDTH-1:0] w_word;
    logic             w_err;
    logic             w_cnt_last;
    logic             w_capture;

    assign w_sel      = MODE ? cnt_q : S;
    assign w_cnt_last = (cnt_q == c_last_ch);

    // Zero-extend the select before comparing so that the check is
    // well-defined whether or not N fills the whole select range; when
    // N == 2**SEL_W this folds to a constant 0.
    assign w_err      = (32'(w_sel) >= c_n);

    // Single-entry pipeline: a word can be loaded whenever the register is
    // empty or is being drained on this same edge.
    assign in_ready   = !out_valid_q || out_ready;
    assign w_capture  = in_valid && in_ready;

    // Word selection by explicit compare so that an out-of-range select
    // matches no channel and yields an all-zero word instead of reading
    // past the end of D.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_word = D[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        y_d         = y_q;
        y_sel_d     = y_sel_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        if (w_capture) begin
            y_d         = w_word;
            y_sel_d     = w_sel;
            err_d       = w_err;
            wrap_d      = MODE && w_cnt_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            // Word consumed with nothing new behind it; data fields keep
            // their stale contents and are ignored while out_valid is low.
            out_valid_d = 1'b0;
        end
    end

    // Scan counter: held at 0 in direct mode so that entering scan mode
    // always begins at channel 0; advances only on an actual capture so a
    // stall never skips a channel.
    always_comb begin
        cnt_d = cnt_q;
        if (!MODE) begin
            cnt_d = '0;
        end else if (w_capture) begin
            cnt_d = w_cnt_last ? '0 : cnt_q + SEL_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            y_q         <= '0;
            y_sel_q     <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            y_sel_q     <= y_sel_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Y         = y_q;
    assign Y_SEL     = y_sel_q;
    assign WRAP      = wrap_q;
    assign ERR       = err_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_reg_n_para_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_reg_n_para_1
//  Description : Scoreboard bench for mux_reg_n_para_1. Two instances: one
//                with N=8 (full select range) and one with N=6 (out-of-range
//                selects possible). The driver pushes hand-computed expected
//                words; per-instance monitors pop and compare on each
//                completed output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_reg_n_para_1;

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] sel;
        logic       wrap;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst;

    // N=8 instance
    logic [31:0] d8;
    logic [2:0]  s8;
    logic        mode8, iv8, ir8, ov8, or8, wrap8, err8;
    logic [3:0]  y8;
    logic [2:0]  ysel8;

    // N=6 instance
    logic [23:0] d6;
    logic [2:0]  s6;
    logic        mode6, iv6, ir6, ov6, or6, wrap6, err6;
    logic [3:0]  y6;
    logic [2:0]  ysel6;

    exp_t q8[$];
    exp_t q6[$];
    exp_t e8, e6;

    int n_checks = 0;
    int n_fail   = 0;

    mux_reg_n_para_1 #(.WIDTH(4), .N(8), .SEL_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .D(d8), .S(s8), .MODE(mode8),
        .in_valid(iv8), .in_ready(ir8), .Y(y8), .Y_SEL(ysel8),
        .out_valid(ov8), .out_ready(or8), .WRAP(wrap8), .ERR(err8)
    );

    mux_reg_n_para_1 #(.WIDTH(4), .N(6), .SEL_W(3)) u_dut6 (
        .clk(clk), .rst(rst), .D(d6), .S(s6), .MODE(mode6),
        .in_valid(iv6), .in_ready(ir6), .Y(y6), .Y_SEL(ysel6),
        .out_valid(ov6), .out_ready(or6), .WRAP(wrap6), .ERR(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [3:0] y, input logic [2:0] s, input logic w, input logic e);
        exp_t x;
        x = '{y: y, sel: s, wrap: w, err: e};
        q8.push_back(x);
    endtask

    task automatic push6(input logic [3:0] y, input logic [2:0] s, input logic w, input logic e);
        exp_t x;
        x = '{y: y, sel: s, wrap: w, err: e};
        q6.push_back(x);
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, " out_valid"}, 32'(ov8),   32'd0);
        chk({tag, " Y"},         32'(y8),    32'd0);
        chk({tag, " Y_SEL"},     32'(ysel8), 32'd0);
        chk({tag, " WRAP"},      32'(wrap8), 32'd0);
        chk({tag, " ERR"},       32'(err8),  32'd0);
        chk({tag, " in_ready"},  32'(ir8),   32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Monitors: a word transfers on the next rising edge when out_valid and
    // out_ready are both high mid-cycle.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut8 unexpected word: Y=%0h Y_SEL=%0d expected none", y8, ysel8);
            end else begin
                e8 = q8.pop_front();
                chk("dut8 Y",     32'(y8),    32'(e8.y));
                chk("dut8 Y_SEL", 32'(ysel8), 32'(e8.sel));
                chk("dut8 WRAP",  32'(wrap8), 32'(e8.wrap));
                chk("dut8 ERR",   32'(err8),  32'(e8.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov6 && or6) begin
            if (q6.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut6 unexpected word: Y=%0h Y_SEL=%0d expected none", y6, ysel6);
            end else begin
                e6 = q6.pop_front();
                chk("dut6 Y",     32'(y6),    32'(e6.y));
                chk("dut6 Y_SEL", 32'(ysel6), 32'(e6.sel));
                chk("dut6 WRAP",  32'(wrap6), 32'(e6.wrap));
                chk("dut6 ERR",   32'(err6),  32'(e6.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b1; mode8 = 1'b0; s8 = '0;
        iv6 = 1'b0; or6 = 1'b1; mode6 = 1'b0; s6 = '0;
        for (int k = 0; k < 8; k++) d8[k*4 +: 4] = 4'(k + 3);
        for (int k = 0; k < 6; k++) d6[k*4 +: 4] = 4'(k + 3);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset8("reset");
        chk("reset dut6 out_valid", 32'(ov6), 32'd0);
        step();

        // Direct mode: S = 0..7, D[k] = k+3
        for (int k = 0; k < 8; k++) begin
            s8  = 3'(k);
            iv8 = 1'b1;
            push8(4'(k + 3), 3'(k), 1'b0, 1'b0);
            @(negedge clk);
            chk("direct in_ready", 32'(ir8), 32'd1);
            step();
        end
        iv8 = 1'b0;
        step();

        // Scan mode: 10 captures, channels 0..7,0,1
        mode8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv8 = 1'b1;
            push8(4'((i % 8) + 3), 3'(i % 8), (i % 8) == 7, 1'b0);
            @(negedge clk);
            chk("scan in_ready", 32'(ir8), 32'd1);
            step();
        end
        iv8 = 1'b0;
        step();

        // Backpressure: capture channel 2 (cnt=2), then stall 3 cycles
        iv8 = 1'b1;
        push8(4'd5, 3'd2, 1'b0, 1'b0);
        step();
        or8 = 1'b0;
        d8  = '1;
        for (int j = 0; j < 3; j++) begin
            s8 = 3'(j + 4);
            @(negedge clk);
            chk("stall in_ready",  32'(ir8),   32'd0);
            chk("stall out_valid", 32'(ov8),   32'd1);
            chk("stall Y_SEL",     32'(ysel8), 32'd2);
            chk("stall Y",         32'(y8),    32'd5);
            step();
        end
        for (int k = 0; k < 8; k++) d8[k*4 +: 4] = 4'(k + 3);
        or8 = 1'b1;
        // Drain and load on the same edge; cnt resumes at 3
        push8(4'd6, 3'd3, 1'b0, 1'b0);
        step();

        // Mode switch mid-scan (cnt=4): one direct capture of S=1, then scan restarts at 0
        mode8 = 1'b0;
        s8    = 3'd1;
        push8(4'd4, 3'd1, 1'b0, 1'b0);
        step();
        mode8 = 1'b1;
        push8(4'd3, 3'd0, 1'b0, 1'b0);
        step();
        push8(4'd4, 3'd1, 1'b0, 1'b0);
        step();

        // Reset mid-operation: scan channels 2,3,4 (cnt -> 5), hold channel 4
        push8(4'd5, 3'd2, 1'b0, 1'b0);
        step();
        push8(4'd6, 3'd3, 1'b0, 1'b0);
        step();
        step();                         // channel 4 word is later discarded by reset
        or8 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pre-reset out_valid", 32'(ov8),   32'd1);
        chk("pre-reset Y_SEL",     32'(ysel8), 32'd4);
        chk("pre-reset in_ready",  32'(ir8),   32'd0);
        step();
        rst = 1'b0;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        chk_reset8("mid-reset");
        step();
        iv8 = 1'b1;
        push8(4'd3, 3'd0, 1'b0, 1'b0);
        step();
        iv8 = 1'b0;
        step();

        // N=6 instance: out-of-range selects, then scan wrap at channel 5
        s6  = 3'd7;
        iv6 = 1'b1;
        push6(4'd0, 3'd7, 1'b0, 1'b1);
        @(negedge clk);
        chk("dut6 in_ready", 32'(ir6), 32'd1);
        step();
        s6 = 3'd5;
        push6(4'd8, 3'd5, 1'b0, 1'b0);
        step();
        s6 = 3'd6;
        push6(4'd0, 3'd6, 1'b0, 1'b1);
        step();
        mode6 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push6(4'((i % 6) + 3), 3'(i % 6), (i % 6) == 5, 1'b0);
            step();
        end
        iv6 = 1'b0;
        step();
        step();
        step();

        chk("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
        chk("dut6 scoreboard drained", 32'(q6.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
